// File: rtl/fp_align_shift.sv
// fp_align_shift: sequential alignment stage of the floating-point adder.
// Restores hidden bits, then right-shifts the smaller significand one bit per
// cycle, collecting guard, round and sticky bits. One transaction in flight at a time.
module fp_align_shift #(
  parameter int SIG_W     = 23,
  parameter int SHIFT_W   = 8,
  parameter int MAX_SHIFT = 26
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SIG_W-1:0]   sig1_in,
  input  logic [SIG_W-1:0]   sig2_in,
  input  logic               hid1_in,
  input  logic               hid2_in,
  input  logic [SHIFT_W-1:0] shift_in,
  input  logic               swap_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SIG_W:0]     sig1_out,
  output logic [SIG_W:0]     sig2_out,
  output logic               guard_out,
  output logic               round_out,
  output logic               sticky_out,
  output logic               swap_out
);

  // Shift register holds {hidden, fraction, guard, round}.
  localparam int S_W = SIG_W + 3;
  localparam logic [SHIFT_W-1:0] CAP     = SHIFT_W'(MAX_SHIFT);
  localparam logic [SHIFT_W-1:0] CNT_ONE = SHIFT_W'(1);
  localparam logic [SHIFT_W-1:0] CNT_ZERO = SHIFT_W'(0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [SIG_W:0]     r_a;
  logic [S_W-1:0]     r_s;
  logic               r_st;
  logic               r_swap;
  logic [SHIFT_W-1:0] r_cnt;
  logic [SHIFT_W-1:0] w_cnt_init;
  logic               w_in_ready;
  logic               w_out_valid;

  // Saturate the requested shift at full SHIFT_W width before loading the counter.
  always_comb begin
    w_cnt_init = shift_in;
    if (shift_in > CAP) begin
      w_cnt_init = CAP;
    end else begin
      w_cnt_init = shift_in;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; handshake flags are decoded from state only.
  always_comb begin
    w_next      = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      IDLE: begin
        w_in_ready = 1'b1;
        if (in_valid) begin
          if (w_cnt_init == CNT_ZERO) begin
            w_next = DONE;
          end else begin
            w_next = SHIFT;
          end
        end else begin
          w_next = IDLE;
        end
      end
      SHIFT: begin
        // <= rather than == so a zero count can never strand the FSM here.
        if (r_cnt <= CNT_ONE) begin
          w_next = DONE;
        end else begin
          w_next = SHIFT;
        end
      end
      DONE: begin
        w_out_valid = 1'b1;
        if (out_ready) begin
          w_next = IDLE;
        end else begin
          w_next = DONE;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Datapath: load on accept, shift one bit per SHIFT cycle, hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a    <= '0;
      r_s    <= '0;
      r_st   <= 1'b0;
      r_swap <= 1'b0;
      r_cnt  <= CNT_ZERO;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a    <= {hid1_in, sig1_in};
            r_s    <= {hid2_in, sig2_in, 2'b00};
            r_st   <= 1'b0;
            r_swap <= swap_in;
            r_cnt  <= w_cnt_init;
          end
        end
        SHIFT: begin
          if (r_cnt != CNT_ZERO) begin
            r_st  <= r_st | r_s[0];
            r_s   <= {1'b0, r_s[S_W-1:1]};
            r_cnt <= r_cnt - CNT_ONE;
          end
        end
        default: begin
          r_cnt <= r_cnt;
        end
      endcase
    end
  end

  assign in_ready   = w_in_ready;
  assign out_valid  = w_out_valid;
  assign sig1_out   = r_a;
  assign sig2_out   = r_s[S_W-1:2];
  assign guard_out  = r_s[1];
  assign round_out  = r_s[0];
  assign sticky_out = r_st;
  assign swap_out   = r_swap;

endmodule

// File: tb/tb_fp_align_shift.sv
// Self-checking bench for fp_align_shift: directed plan plus random transactions
// compared with an arithmetic alignment model.
module tb_fp_align_shift;

  localparam int SIG_W   = 23;
  localparam int SHIFT_W = 8;

  logic               clk;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic [SIG_W-1:0]   sig1_in;
  logic [SIG_W-1:0]   sig2_in;
  logic               hid1_in;
  logic               hid2_in;
  logic [SHIFT_W-1:0] shift_in;
  logic               swap_in;
  logic               out_valid;
  logic               out_ready;
  logic [SIG_W:0]     sig1_out;
  logic [SIG_W:0]     sig2_out;
  logic               guard_out;
  logic               round_out;
  logic               sticky_out;
  logic               swap_out;

  int n_asserts = 0;
  int n_fail    = 0;

  fp_align_shift #(.SIG_W(SIG_W), .SHIFT_W(SHIFT_W), .MAX_SHIFT(26)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .sig1_in(sig1_in), .sig2_in(sig2_in), .hid1_in(hid1_in), .hid2_in(hid2_in),
    .shift_in(shift_in), .swap_in(swap_in), .out_valid(out_valid),
    .out_ready(out_ready), .sig1_out(sig1_out), .sig2_out(sig2_out),
    .guard_out(guard_out), .round_out(round_out), .sticky_out(sticky_out),
    .swap_out(swap_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Caller is positioned at a negedge; returns positioned at a negedge in IDLE.
  task automatic run_txn(input logic [SIG_W-1:0] s1, input logic [SIG_W-1:0] s2,
                         input logic h1, input logic h2, input int sh,
                         input logic sw, input int hold, input bit keep_valid);
    logic [63:0] full, shifted, e_sig2, e_g, e_r, e_st;
    int k, lat, n;
    k       = (sh > 26) ? 26 : sh;
    full    = {38'd0, h2, s2, 2'b00};
    shifted = full >> k;
    e_sig2  = (shifted >> 2) & 64'hFF_FFFF;
    e_g     = (shifted >> 1) & 64'd1;
    e_r     = shifted & 64'd1;
    e_st    = ((full & ((64'd1 << k) - 64'd1)) != 64'd0) ? 64'd1 : 64'd0;

    sig1_in = s1; sig2_in = s2; hid1_in = h1; hid2_in = h2;
    shift_in = SHIFT_W'(sh); swap_in = sw; in_valid = 1'b1;
    out_ready = (hold == 0);
    n = 0;
    while (!in_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_before_accept", {63'd0, in_ready}, 64'd1);
    chk("out_valid_before_accept", {63'd0, out_valid}, 64'd0);
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    if (!keep_valid) in_valid = 1'b0;
    while (!out_valid && lat < 40) begin
      chk("in_ready_busy", {63'd0, in_ready}, 64'd0);
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    chk("latency", 64'(lat), 64'(k + 1));
    chk("out_valid", {63'd0, out_valid}, 64'd1);
    chk("in_ready_done", {63'd0, in_ready}, 64'd0);
    chk("sig1_out", 64'(sig1_out), {40'd0, h1, s1});
    chk("sig2_out", 64'(sig2_out), e_sig2);
    chk("guard", {63'd0, guard_out}, e_g);
    chk("round", {63'd0, round_out}, e_r);
    chk("sticky", {63'd0, sticky_out}, e_st);
    chk("swap_out", {63'd0, swap_out}, {63'd0, sw});
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
      chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
      chk("bp_sig2_stable", 64'(sig2_out), e_sig2);
      chk("bp_grs_stable", {61'd0, guard_out, round_out, sticky_out},
          (e_g << 2) | (e_r << 1) | e_st);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("in_ready_after_hs", {63'd0, in_ready}, 64'd1);
    chk("out_valid_after_hs", {63'd0, out_valid}, 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    sig1_in = '0; sig2_in = '0; hid1_in = 1'b0; hid2_in = 1'b0;
    shift_in = '0; swap_in = 1'b0;
    #12;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_sig2", 64'(sig2_out), 64'd0);
    chk("rst_sig1", 64'(sig1_out), 64'd0);
    chk("rst_grs_swap", {60'd0, guard_out, round_out, sticky_out, swap_out}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Zero shift
    run_txn(23'h000000, 23'h400000, 1'b0, 1'b1, 0, 1'b0, 0, 1'b0);
    // Shift 3
    run_txn(23'h123456, 23'h000007, 1'b1, 1'b1, 3, 1'b1, 0, 1'b0);
    // Saturating shift, sticky from hidden bit, then all-zero
    run_txn(23'h7FFFFF, 23'h000000, 1'b1, 1'b1, 200, 1'b0, 0, 1'b0);
    run_txn(23'h000001, 23'h000000, 1'b1, 1'b0, 200, 1'b0, 0, 1'b0);
    // Cap boundary
    run_txn(23'h000000, 23'h7FFFFF, 1'b1, 1'b1, 26, 1'b0, 0, 1'b0);
    run_txn(23'h000000, 23'h7FFFFF, 1'b1, 1'b1, 25, 1'b1, 0, 1'b0);
    // Backpressure
    run_txn(23'h2AAAAA, 23'h555555, 1'b1, 1'b1, 7, 1'b1, 5, 1'b0);

    // Reset mid-shift
    sig1_in = 23'h3C3C3C; sig2_in = 23'h7F00FF; hid1_in = 1'b1; hid2_in = 1'b1;
    shift_in = 8'd20; swap_in = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("midrst_sig1", 64'(sig1_out), 64'd0);
    chk("midrst_sig2", 64'(sig2_out), 64'd0);
    chk("midrst_grs_swap", {60'd0, guard_out, round_out, sticky_out, swap_out}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("postrst_out_valid", {63'd0, out_valid}, 64'd0);
    run_txn(23'h000000, 23'h000001, 1'b0, 1'b0, 1, 1'b0, 0, 1'b0);

    // Back-to-back with swap, in_valid held high
    run_txn(23'h0F0F0F, 23'h00F0F0, 1'b1, 1'b1, 4, 1'b1, 0, 1'b1);
    run_txn(23'h0F0F0F, 23'h00F0F0, 1'b1, 1'b0, 2, 1'b0, 0, 1'b1);
    in_valid = 1'b0;

    // Random transactions
    for (int t = 0; t < 25; t++) begin
      run_txn(SIG_W'($urandom), SIG_W'($urandom), 1'($urandom), 1'($urandom),
              ($urandom_range(0, 7) == 0) ? int'($urandom_range(27, 255))
                                          : int'($urandom_range(0, 28)),
              1'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
    end
    in_valid = 1'b0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_align_shift.md
# fp_align_shift

Sequential alignment stage of the floating-point adder. Consumes the ordered significands, shift amount and swap flag from the operand-swap stage, restores hidden bits, and right-shifts the smaller significand one bit per cycle into a 24-bit aligned value plus guard, round and sticky bits. Results go to the significand add/subtract stage over a valid/ready handshake.

## Interface
- `SIG_W`, default 23: stored fraction width.
- `SHIFT_W`, default 8: shift amount width.
- `MAX_SHIFT`, default 26: shift cap, equal to SIG_W+1 plus the guard and round bits.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  upstream data valid.
- `in_ready`  out  1  block can accept a new operand pair.
- `sig1_in`  in  SIG_W  larger-operand fraction, after swap.
- `sig2_in`  in  SIG_W  smaller-operand fraction, after swap.
- `hid1_in`, `hid2_in`  in  1 each  hidden bit per operand: 1 if exponent is nonzero, 0 if denormal.
- `shift_in`  in  SHIFT_W  exponent difference, unsigned and already positive.
- `swap_in`  in  1  swap flag from the previous stage.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accepts the result.
- `sig1_out`  out  SIG_W+1  {hid1, sig1}, unshifted.
- `sig2_out`  out  SIG_W+1  aligned {hid2, sig2}.
- `guard_out`, `round_out`, `sticky_out`  out  1 each  bits below the LSB of `sig2_out`.
- `swap_out`  out  1  registered copy of `swap_in`.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid`&&`in_ready`, the block:
    - loads A={hid1_in,sig1_in};
    - loads shift register S[25:0]={hid2_in,sig2_in,1'b0,1'b0};
    - clears the sticky bit (ST=0);
    - registers `swap_in`;
    - sets cnt = min(shift_in, MAX_SHIFT), with the comparison done at full SHIFT_W width.
  - If cnt==0, go to DONE. Otherwise go to SHIFT.
- **SHIFT**
  - Each cycle: ST <= ST | S[0]; S <= S>>1 with a zero fill; cnt <= cnt-1.
  - When cnt==1 at the edge, go to DONE.
  - `in_valid` is ignored.
- **DONE**
  - `out_valid`=1.
  - Outputs: `sig2_out`=S[25:2], `guard_out`=S[1], `round_out`=S[0], `sticky_out`=ST.
  - Output values are stable while `out_valid`&&!`out_ready`.
  - On `out_ready`, go to IDLE.
- Shift amounts ≥26 give `sig2_out`=0, G=0, R=0. ST is the OR of all 24 significand bits.
- All arithmetic is unsigned. cnt is SHIFT_W bits wide and never underflows.
- A new operand pair is never accepted in DONE. The block holds one transaction at a time and has no bypass path.

## Timing
- Reset (asynchronous, active-low):
  - Forces IDLE.
  - Resets `out_valid`=0, `in_ready`=1 (combinational from IDLE), all data outputs 0, `swap_out`=0, cnt=0, ST=0.
- Latency from the accept edge to the first `out_valid` cycle is k+1 cycles, where k=min(shift_in,26).
  - shift_in=0 gives `out_valid` in the cycle after accept.
  - Worst case is 27 cycles.
- Throughput is one transaction per k+2 cycles at best. IDLE costs one cycle between transactions.
- Reset asserted mid-SHIFT or in DONE aborts the transaction immediately. No partial result is presented after reset deasserts.
- `in_ready` and `out_valid` are never high in the same cycle.
- `in_ready` and `out_valid` are decoded from state only, with no combinational path from `in_valid` or `out_ready`.

## Test plan
- **Zero shift:** sig1=0x000000, sig2=0x400000, hid2=1, shift=0.
  - Expect `out_valid` one cycle after accept, `sig2_out`=0xC00000, G=R=ST=0.
- **Shift 3:** sig2=0x000007, hid2=1, shift=3.
  - Expect `sig2_out`=0x100000, G=1, R=1, ST=1, `out_valid` exactly 4 cycles after accept.
- **Saturating shift:** shift=200, hid2=1, sig2=0.
  - Expect `out_valid` 27 cycles after accept, `sig2_out`=0, G=R=0, ST=1.
  - Repeat with hid2=0, sig2=0: expect ST=0.
- **Backpressure:** hold `out_ready`=0 for 5 cycles in DONE.
  - Expect outputs stable and `in_ready`=0 throughout.
  - Release `out_ready`: expect `in_ready`=1 the next cycle.
- **Reset mid-shift:** shift=20, assert `rst_n`=0 at shift cycle 5.
  - Expect IDLE, `out_valid`=0 and all outputs 0 asynchronously.
  - Next transaction with shift=1, sig2=0x000001, hid2=0: expect `sig2_out`=0, G=1, R=0, ST=0.
- **Back-to-back with swap:** send swap=1 then swap=0, with `in_valid` held high.
  - Expect `swap_out` to match per transaction.
  - Expect the second accept only in the cycle after the first handshake completes.
